// File: rtl/jump_pkg.sv
// jump_pkg: shared widths and FSM states for the jump redirect unit
package jump_pkg;
  localparam int PC_W_DEF = 16;
  localparam int DISP_W = 11;
  localparam int IMM_W = 8;
  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;
endpackage

// File: rtl/jump_target_calc.sv
// jump_target_calc: halfword-aligned jump target (pc_plus2+sext(disp) or rs_val+sext(imm8)) -> target
module jump_target_calc
  import jump_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic              jr_jalr_en,
  input  logic [PC_W-1:0]   pc_plus2,
  input  logic [DISP_W-1:0] disp,
  input  logic [PC_W-1:0]   rs_val,
  input  logic [IMM_W-1:0]  imm8,
  output logic [PC_W-1:0]   target
);
  logic [PC_W-1:0] sum;
  assign sum = jr_jalr_en ? rs_val + {{(PC_W-IMM_W){imm8[IMM_W-1]}}, imm8}
                          : pc_plus2 + {{(PC_W-DISP_W){disp[DISP_W-1]}}, disp};
  assign target = {sum[PC_W-1:1], 1'b0};
endmodule

// File: rtl/jump_redirect_unit.sv
// jump_redirect_unit: jump accept/redirect FSM; in: stall, jump request, operands; out: pc, ack, flush, link_we/link_data, busy, err
module jump_redirect_unit
  import jump_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic              jal_j_en,
  input  logic              jr_jalr_en,
  input  logic              link_en,
  input  logic [PC_W-1:0]   pc_plus2,
  input  logic [DISP_W-1:0] disp,
  input  logic [PC_W-1:0]   rs_val,
  input  logic [IMM_W-1:0]  imm8,
  output logic [PC_W-1:0]   pc,
  output logic              ack,
  output logic              flush,
  output logic              link_we,
  output logic [PC_W-1:0]   link_data,
  output logic              busy,
  output logic              err
);
  state_t state, state_nx;
  logic [PC_W-1:0] target, tgt_q, pc_nx;
  logic idle, req_ok;
  jump_target_calc #(.PC_W(PC_W)) u_calc (
    .jr_jalr_en(jr_jalr_en),
    .pc_plus2(pc_plus2),
    .disp(disp),
    .rs_val(rs_val),
    .imm8(imm8),
    .target(target)
  );
  assign idle = state == IDLE;
  assign req_ok = jump_valid && (jal_j_en ^ jr_jalr_en);
  assign ack = idle && req_ok;
  assign busy = state == PENDING;
  assign flush = state == FLUSH;
  always_comb begin
    state_nx = (ack || busy) ? (stall ? PENDING : FLUSH) : IDLE;
    pc_nx = stall ? pc : ack ? target : busy ? tgt_q : pc + PC_W'(2);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      tgt_q <= '0;
      link_we <= 1'b0;
      link_data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      tgt_q <= ack ? target : tgt_q;
      link_we <= ack && link_en;
      link_data <= (ack && link_en) ? pc_plus2 : link_data;
      err <= idle && jump_valid && !req_ok;
    end
  end
endmodule
